line_clear: RTL and testbench

Line-clear engine between the game-logic lock step and the next spawn. On a `start` pulse it scans the 10×20 board memory bottom-up, removes every full row, and compacts the surviving rows downward. It then zero-fills the vacated top rows and reports how many lines were removed. It owns the board read/write ports only while `busy` is high.

---
 rtl/line_clear_if.sv | 22 ++
 rtl/line_clear.sv | 146 ++++++++++++++
 tb/tb_line_clear.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/line_clear_if.sv
// line_clear_if: start/status handshake plus the board read/write port of the line-clear engine.
interface line_clear_if;
  logic       start;
  logic       board_rdata;
  logic [3:0] board_rx;
  logic [4:0] board_ry;
  logic       board_we;
  logic [3:0] board_wx;
  logic [4:0] board_wy;
  logic       board_wdata;
  logic       busy;
  logic       done;
  logic [4:0] lines_cleared;
  modport master (
    input  start, board_rdata,
    output board_rx, board_ry, board_we, board_wx, board_wy, board_wdata, busy, done, lines_cleared
  );
  modport slave (
    output start, board_rdata,
    input  board_rx, board_ry, board_we, board_wx, board_wy, board_wdata, busy, done, lines_cleared
  );
endinterface

// File: rtl/line_clear.sv
// line_clear: bottom-up full-row removal and compaction of the board memory.
// Define LINE_CLEAR_EARLY_EXIT_EN to stop the scan at the first empty row.
module line_clear #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input logic          CLOCK_50,
  input logic          reset,
  line_clear_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, FILL, DONE} state_t;
  localparam logic [3:0] LAST   = 4'(COLS - 1);
  localparam logic [3:0] RD_END = 4'(COLS);
  localparam logic [4:0] BOT    = 5'(ROWS - 1);
  localparam logic [4:0] CMAX   = 5'(ROWS);
  state_t state_q, state_d;
  logic [4:0] src_q, src_d, dst_q, dst_d, cnt_q, cnt_d, lc_q, lc_d;
  logic [3:0] col_q, col_d;
  logic [COLS-1:0] rowbuf_q, rowbuf_d;
  logic adv, stop;
  logic busy_q, busy_d, done_q, done_d, we_q, we_d, wdata_q, wdata_d;
  logic [3:0] rx_q, rx_d, wx_q, wx_d;
  logic [4:0] ry_q, ry_d, wy_q, wy_d;
  logic rd, wr;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.lines_cleared = lc_q;
  assign bus.board_rx      = rx_q;
  assign bus.board_ry      = ry_q;
  assign bus.board_we      = we_q;
  assign bus.board_wx      = wx_q;
  assign bus.board_wy      = wy_q;
  assign bus.board_wdata   = wdata_q;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      col_q    <= '0;
      rowbuf_q <= '0;
      lc_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= 1'b0;
      rx_q     <= '0;
      ry_q     <= '0;
      wx_q     <= '0;
      wy_q     <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      rowbuf_q <= rowbuf_d;
      lc_q     <= lc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rx_q     <= rx_d;
      ry_q     <= ry_d;
      wx_q     <= wx_d;
      wy_q     <= wy_d;
    end
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    col_d    = col_q;
    rowbuf_d = rowbuf_q;
    adv      = 1'b0;
    stop     = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = READ;
        src_d   = BOT;
        dst_d   = BOT;
        cnt_d   = '0;
        col_d   = '0;
      end
      READ: begin
        if (col_q != 4'd0) rowbuf_d[col_q - 4'd1] = bus.board_rdata;
        col_d   = col_q == RD_END ? 4'd0 : col_q + 4'd1;
        state_d = col_q == RD_END ? CHECK : READ;
      end
      CHECK: begin
        if (&rowbuf_q) begin
          cnt_d = cnt_q == CMAX ? cnt_q : cnt_q + 5'd1;
          adv   = 1'b1;
        end
`ifdef LINE_CLEAR_EARLY_EXIT_EN
        else if (~|rowbuf_q) stop = 1'b1;
`endif
        else if (src_q != dst_q) state_d = WRITE;
        else begin
          dst_d = dst_q - 5'd1;
          adv   = 1'b1;
        end
      end
      WRITE: begin
        col_d = col_q == LAST ? 4'd0 : col_q + 4'd1;
        if (col_q == LAST) begin
          dst_d = dst_q - 5'd1;
          adv   = 1'b1;
        end
      end
      FILL: begin
        col_d = col_q == LAST ? 4'd0 : col_q + 4'd1;
        if (col_q == LAST) begin
          if (src_q == 5'd0) state_d = DONE;
          else begin
            src_d = src_q - 5'd1;
            dst_d = dst_q - 5'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // once the scan is over, src is reused as the count of rows still to zero-fill
    if (adv && src_q != 5'd0) begin
      src_d   = src_q - 5'd1;
      state_d = READ;
    end else if (adv || stop) begin
      state_d = cnt_d != 5'd0 ? FILL : DONE;
      src_d   = cnt_d - 5'd1;
    end
  end
  always_comb begin
    rd      = state_d == READ && col_d < RD_END;
    wr      = state_d == WRITE || state_d == FILL;
    busy_d  = state_d != IDLE;
    done_d  = state_d == DONE;
    we_d    = wr;
    wx_d    = wr ? col_d : 4'd0;
    wy_d    = wr ? dst_d : 5'd0;
    wdata_d = state_d == WRITE ? rowbuf_d[col_d] : 1'b0;
    rx_d    = rd ? col_d : 4'd0;
    ry_d    = rd ? src_d : 5'd0;
    lc_d    = state_d == DONE ? cnt_d : (state_q == IDLE && bus.start) ? 5'd0 : lc_q;
  end
endmodule

// File: tb/tb_line_clear.sv
// tb_line_clear: random and directed boards checked against a row-list model of line clearing.
module tb_line_clear;
  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam logic [COLS-1:0] FULL = '1;
`ifdef LINE_CLEAR_EARLY_EXIT_EN
  localparam int EMPTY_BUSY = 13;
`else
  localparam int EMPTY_BUSY = 241;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  line_clear_if bus();
  line_clear #(.COLS(COLS), .ROWS(ROWS)) dut (.CLOCK_50(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] init [ROWS];
  logic [COLS-1:0] expb [ROWS];
  int checks = 0;
  int errors = 0;
  int exp_lc, exp_busy, exp_wr;
  int busy_cyc, n_done, n_wr, viol;
  bit tmo;

  // board memory with one-cycle read latency
  always @(posedge clk) begin
    bus.board_rdata <= mem[bus.board_ry][bus.board_rx];
    if (bus.board_we) mem[bus.board_wy][bus.board_wx] <= bus.board_wdata;
  end

  task automatic load_board();
    for (int r = 0; r < ROWS; r++) mem[r] <= init[r];
    @(negedge clk);
  endtask

  // expected result: surviving rows stacked from the bottom in order, plus cycle and write counts
  task automatic model();
    logic [COLS-1:0] kept [$];
    bit halt;
    int tgt;
    exp_lc = 0;
    exp_busy = 1;
    exp_wr = 0;
    halt = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!halt) begin
        exp_busy += 12;
        if (init[r] == FULL) begin
          exp_lc++;
          exp_busy += 10;
          exp_wr += 10;
        end
`ifdef LINE_CLEAR_EARLY_EXIT_EN
        else if (init[r] == '0) halt = 1;
`endif
        else begin
          tgt = ROWS - 1 - kept.size();
          if (tgt != r) begin
            exp_busy += 10;
            exp_wr += 10;
          end
          kept.push_back(init[r]);
        end
      end
    end
    for (int r = 0; r < ROWS; r++) expb[r] = '0;
    for (int i = 0; i < kept.size(); i++) expb[ROWS - 1 - i] = kept[i];
  endtask

  task automatic run_pass(input int restart);
    int post;
    viol = 0;
    busy_cyc = 0;
    n_done = 0;
    n_wr = 0;
    tmo = 1;
    post = -1;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (bus.busy) busy_cyc++;
      if (bus.done) n_done++;
      if (bus.board_we) n_wr++;
      if (!bus.board_we && (bus.board_wx != 0 || bus.board_wy != 0 || bus.board_wdata != 0)) viol++;
      if (bus.done && post < 0) post = 4;
      bus.start = (k == restart);
      if (post > 0) post--;
      if (post == 0) begin
        tmo = 0;
        break;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.board_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus.board_we); end
    checks++; if (bus.lines_cleared !== 5'd0) begin errors++; $display("FAIL reset_lc got %0d want 0", bus.lines_cleared); end
    checks++; if ({bus.board_rx, bus.board_ry, bus.board_wx, bus.board_wy, bus.board_wdata} !== 19'd0) begin
      errors++; $display("FAIL reset_addr got rx=%0d ry=%0d wx=%0d wy=%0d wd=%b want all 0",
                        bus.board_rx, bus.board_ry, bus.board_wx, bus.board_wy, bus.board_wdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_empty();
    for (int r = 0; r < ROWS; r++) init[r] = '0;
    load_board();
    run_pass(-1);
    checks++; if (tmo) begin errors++; $display("FAIL empty_timeout no done pulse"); end
    checks++; if (busy_cyc !== EMPTY_BUSY) begin errors++; $display("FAIL empty_busy got %0d want %0d", busy_cyc, EMPTY_BUSY); end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL empty_done got %0d want 1", n_done); end
    checks++; if (n_wr !== 0) begin errors++; $display("FAIL empty_writes got %0d want 0", n_wr); end
    checks++; if (bus.lines_cleared !== 5'd0) begin errors++; $display("FAIL empty_lc got %0d want 0", bus.lines_cleared); end
  endtask

  task automatic test_patterns();
    int h;
    for (int t = 0; t < 11; t++) begin
      for (int r = 0; r < ROWS; r++) init[r] = '0;
      case (t)
        0: begin init[19] = FULL; init[18] = 10'h001; end
        1: begin for (int r = 16; r < 20; r++) init[r] = FULL; init[15] = 10'h155; end
        2: begin init[19] = FULL; init[18] = 10'h020; init[17] = FULL; init[16] = 10'h200; end
        default: begin
          h = $urandom_range(0, ROWS);
          for (int i = 0; i < h; i++) begin
            init[ROWS - 1 - i] = FULL;
            if ($urandom_range(0, 2) != 0) init[ROWS - 1 - i] = COLS'($urandom_range(1, (1 << COLS) - 2));
          end
        end
      endcase
      load_board();
      model();
      run_pass(-1);
      checks++; if (tmo) begin errors++; $display("FAIL pat%0d_timeout no done pulse", t); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL pat%0d_done got %0d want 1", t, n_done); end
      checks++; if (busy_cyc !== exp_busy) begin errors++; $display("FAIL pat%0d_busy got %0d want %0d", t, busy_cyc, exp_busy); end
      checks++; if (n_wr !== exp_wr) begin errors++; $display("FAIL pat%0d_writes got %0d want %0d", t, n_wr, exp_wr); end
      checks++; if (viol !== 0) begin errors++; $display("FAIL pat%0d_idle_wbus got %0d nonzero cycles want 0", t, viol); end
      checks++; if (int'(bus.lines_cleared) !== exp_lc) begin errors++; $display("FAIL pat%0d_lc got %0d want %0d", t, bus.lines_cleared, exp_lc); end
      for (int r = 0; r < ROWS; r++) begin
        checks++; if (mem[r] !== expb[r]) begin errors++; $display("FAIL pat%0d_row%0d got %h want %h", t, r, mem[r], expb[r]); end
      end
    end
  endtask

  task automatic test_start_ignored();
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < ROWS; r++) init[r] = '0;
      init[19] = FULL;
      init[18] = 10'h001;
      load_board();
      model();
      run_pass(p == 0 ? 15 : exp_busy - 1);
      checks++; if (tmo) begin errors++; $display("FAIL restart%0d_timeout no done pulse", p); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL restart%0d_done got %0d want 1", p, n_done); end
      checks++; if (busy_cyc !== exp_busy) begin errors++; $display("FAIL restart%0d_busy got %0d want %0d", p, busy_cyc, exp_busy); end
      checks++; if (int'(bus.lines_cleared) !== exp_lc) begin errors++; $display("FAIL restart%0d_lc got %0d want %0d", p, bus.lines_cleared, exp_lc); end
      checks++; if (mem[19] !== 10'h001 || mem[18] !== 10'h000) begin
        errors++; $display("FAIL restart%0d_rows got r19=%h r18=%h want 001 000", p, mem[19], mem[18]);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    for (int r = 0; r < ROWS; r++) init[r] = '0;
    init[19] = FULL;
    init[18] = 10'h001;
    load_board();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    for (int k = 0; k < 200 && !bus.board_we; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (bus.board_we !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL midwr_active got we=%b busy=%b want 1 1", bus.board_we, bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midwr_busy got %b want 0", bus.busy); end
    checks++; if (bus.board_we !== 1'b0) begin errors++; $display("FAIL midwr_we got %b want 0", bus.board_we); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midwr_done got %b want 0", bus.done); end
    checks++; if (bus.lines_cleared !== 5'd0) begin errors++; $display("FAIL midwr_lc got %0d want 0", bus.lines_cleared); end
    #1 rst = 1'b0;
    @(negedge clk);
    for (int r = 0; r < ROWS; r++) init[r] = mem[r];
    model();
    run_pass(-1);
    checks++; if (tmo) begin errors++; $display("FAIL midwr_rerun_timeout no done pulse"); end
    checks++; if (busy_cyc !== exp_busy) begin errors++; $display("FAIL midwr_rerun_busy got %0d want %0d", busy_cyc, exp_busy); end
    checks++; if (int'(bus.lines_cleared) !== exp_lc) begin errors++; $display("FAIL midwr_rerun_lc got %0d want %0d", bus.lines_cleared, exp_lc); end
    for (int r = 0; r < ROWS; r++) begin
      checks++; if (mem[r] !== expb[r]) begin errors++; $display("FAIL midwr_row%0d got %h want %h", r, mem[r], expb[r]); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_empty();
    test_patterns();
    test_start_ignored();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
